// File: rtl/lcd_de_receiver.sv
// DE-mode RGB565 capture: recovers line/frame structure from DE alone, tags each
// pixel with its (x, y) position, measures the geometry and flags mismatches.
module lcd_de_receiver #(
    parameter logic [10:0] H_DISP   = 11'd800,
    parameter logic [10:0] V_DISP   = 11'd480,
    parameter logic [11:0] VGAP_MIN = 12'd1024
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        de_in,
    input  logic [15:0] rgb_in,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_done,
    output logic [10:0] meas_width,
    output logic [10:0] meas_height,
    output logic        err_width,
    output logic        err_height,
    output logic        locked
);

    typedef enum logic [1:0] {S_HUNT, S_VBLANK, S_LINE, S_HBLANK} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_gap;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_frame_err;

    logic        w_gap_hit;
    logic [10:0] w_y_inc;
    logic        w_width_err;
    logic        w_height_err;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign w_gap_hit    = (r_gap >= VGAP_MIN - 12'd1);
    assign w_y_inc      = sat_inc11(r_y);
    assign w_width_err  = (r_x != H_DISP);
    assign w_height_err = (w_y_inc != V_DISP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HUNT:   if (!de_in && w_gap_hit) w_next = S_VBLANK;
            S_VBLANK: if (de_in) w_next = S_LINE;
            S_LINE:   if (!de_in) w_next = S_HBLANK;
            S_HBLANK: begin
                if (de_in)          w_next = S_LINE;
                else if (w_gap_hit) w_next = S_VBLANK;
            end
            default:  w_next = S_HUNT;
        endcase
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_HUNT;
            r_gap       <= 12'd0;
            r_x         <= 11'd0;
            r_y         <= 11'd0;
            r_frame_err <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= 16'd0;
            pix_x       <= 11'd0;
            pix_y       <= 11'd0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            meas_width  <= 11'd0;
            meas_height <= 11'd0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            locked      <= 1'b0;
        end else begin
            r_state     <= w_next;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            if (de_in && r_state != S_HUNT) begin
                pix_valid <= 1'b1;
                pix_data  <= rgb_in;
            end
            case (r_state)
                S_HUNT: r_gap <= de_in ? 12'd0 : sat_inc12(r_gap);
                S_VBLANK: begin
                    if (de_in) begin
                        pix_x       <= 11'd0;
                        pix_y       <= 11'd0;
                        frame_start <= 1'b1;
                        r_x         <= 11'd1;
                        r_y         <= 11'd0;
                        r_frame_err <= 1'b0;
                    end
                end
                S_LINE: begin
                    if (de_in) begin
                        pix_x <= r_x;
                        pix_y <= r_y;
                        r_x   <= sat_inc11(r_x);
                    end else begin
                        line_end   <= 1'b1;
                        meas_width <= r_x;
                        err_width  <= w_width_err;
                        if (w_width_err) begin
                            r_frame_err <= 1'b1;
                            locked      <= 1'b0;
                        end
                        // the line_end cycle itself is the first blank cycle
                        r_gap <= 12'd1;
                    end
                end
                S_HBLANK: begin
                    if (de_in) begin
                        pix_x <= 11'd0;
                        pix_y <= w_y_inc;
                        r_y   <= w_y_inc;
                        r_x   <= 11'd1;
                    end else if (w_gap_hit) begin
                        frame_done  <= 1'b1;
                        meas_height <= w_y_inc;
                        err_height  <= w_height_err;
                        locked      <= !(r_frame_err || w_height_err);
                    end else begin
                        r_gap <= sat_inc12(r_gap);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_de_receiver.sv
// Scoreboard bench for lcd_de_receiver at reduced geometry (8x4, vertical gap 20).
module tb_lcd_de_receiver;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int VG = 20;
    localparam int HB = 6;
    localparam int VB = 30;

    logic        lcd_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        de_in = 1'b0;
    logic [15:0] rgb_in = 16'd0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x, pix_y;
    logic        frame_start, line_end, frame_done;
    logic [10:0] meas_width, meas_height;
    logic        err_width, err_height, locked;

    lcd_de_receiver #(
        .H_DISP(11'(H)), .V_DISP(11'(V)), .VGAP_MIN(12'(VG))
    ) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .de_in(de_in), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_end(line_end), .frame_done(frame_done),
        .meas_width(meas_width), .meas_height(meas_height),
        .err_width(err_width), .err_height(err_height), .locked(locked)
    );

    always #5 lcd_clk = ~lcd_clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] d;
        logic        fs;
    } pix_t;

    typedef struct packed {
        logic [10:0] v;
        logic        err;
        logic        lk;
    } ev_t;

    pix_t pix_q[$];
    ev_t  line_q[$];
    ev_t  frame_q[$];

    int n_checks = 0;
    int n_err = 0;

    // stream-level reference state
    bit m_hunt = 1'b1;
    bit m_inframe = 1'b0;
    int m_y = 0;
    bit m_ferr = 1'b0;
    bit m_locked = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {pix_valid, pix_data, pix_x, pix_y, frame_start, line_end, frame_done,
                   meas_width, meas_height, err_width, err_height, locked}, 96'd0);
    endtask

    task automatic line(input int len);
        pix_t p;
        ev_t  e;
        bit   active;
        bit   fs;
        active = !m_hunt;
        fs = active && !m_inframe;
        if (fs) begin
            m_inframe = 1'b1;
            m_y = 0;
            m_ferr = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            @(posedge lcd_clk); #1;
            de_in  = 1'b1;
            rgb_in = 16'(i + m_y);
            if (active) begin
                p.x = 11'(i); p.y = 11'(m_y); p.d = rgb_in; p.fs = fs && (i == 0);
                pix_q.push_back(p);
            end
        end
        if (active) begin
            e.v = 11'(len);
            e.err = (len != H);
            if (e.err) begin
                m_ferr = 1'b1;
                m_locked = 1'b0;
            end
            e.lk = m_locked;
            line_q.push_back(e);
            m_y++;
        end
    endtask

    task automatic gap(input int n);
        ev_t e;
        if (n >= VG) begin
            if (m_hunt) m_hunt = 1'b0;
            else if (m_inframe) begin
                e.v = 11'(m_y);
                e.err = (m_y != V);
                m_locked = !(m_ferr || e.err);
                e.lk = m_locked;
                frame_q.push_back(e);
                m_inframe = 1'b0;
            end
        end
        repeat (n) begin
            @(posedge lcd_clk); #1;
            de_in  = 1'b0;
            rgb_in = 16'hA5A5;
        end
    endtask

    task automatic frame(input int lines, input int width, input int short_idx);
        for (int l = 0; l < lines; l++) begin
            line((l == short_idx) ? width : H);
            gap((l == lines - 1) ? VB : HB);
        end
    endtask

    pix_t mp;
    ev_t  me;
    always @(negedge lcd_clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) chk("unexpected_pix", pix_valid, 1'b0);
            else begin
                mp = pix_q.pop_front();
                chk("pix_x", pix_x, mp.x);
                chk("pix_y", pix_y, mp.y);
                chk("pix_data", pix_data, mp.d);
                chk("frame_start", frame_start, mp.fs);
            end
        end else if (frame_start) chk("stray_frame_start", frame_start, 1'b0);
        if (line_end) begin
            if (line_q.size() == 0) chk("unexpected_line_end", line_end, 1'b0);
            else begin
                me = line_q.pop_front();
                chk("meas_width", meas_width, me.v);
                chk("err_width", err_width, me.err);
                chk("locked_at_line_end", locked, me.lk);
            end
        end else if (err_width) chk("stray_err_width", err_width, 1'b0);
        if (frame_done) begin
            if (frame_q.size() == 0) chk("unexpected_frame_done", frame_done, 1'b0);
            else begin
                me = frame_q.pop_front();
                chk("meas_height", meas_height, me.v);
                chk("err_height", err_height, me.err);
                chk("locked_at_frame_done", locked, me.lk);
            end
        end else if (err_height) chk("stray_err_height", err_height, 1'b0);
    end

    initial begin
        #2 sys_rst_n = 1'b0;
        repeat (2) @(posedge lcd_clk);
        @(negedge lcd_clk);
        chk_all_zero("reset_outputs");
        @(posedge lcd_clk); #1 sys_rst_n = 1'b1;

        // joined mid-frame: discarded until a vertical gap
        line(H); gap(HB); line(H); gap(HB); line(H); gap(VB);
        frame(V, H, -1);
        chk("locked_after_clean", locked, 1'b1);

        frame(V, H - 1, 2);          // one short line
        frame(V, H, -1);             // recovers
        frame(V - 1, H, -1);         // short frame
        frame(V, H, -1);

        // horizontal gaps just below the vertical threshold stay within a frame
        line(H); gap(VG - 2); line(H); gap(VG - 1); line(H); gap(HB); line(H); gap(VG);
        frame(V, 1, 1);              // single-cycle DE line
        frame(V, H, -1);

        // reset asserted mid-line
        line(H); gap(HB);
        for (int i = 0; i < 3; i++) begin
            @(posedge lcd_clk); #1;
            de_in = 1'b1;
            rgb_in = 16'(i + m_y);
            mp.x = 11'(i); mp.y = 11'(m_y); mp.d = rgb_in; mp.fs = 1'b0;
            pix_q.push_back(mp);
        end
        @(posedge lcd_clk);
        @(negedge lcd_clk); #1;
        sys_rst_n = 1'b0;
        m_hunt = 1'b1; m_inframe = 1'b0; m_locked = 1'b0;
        @(negedge lcd_clk);
        chk_all_zero("reset_mid_line");
        @(posedge lcd_clk); #1 sys_rst_n = 1'b1;
        line(5); gap(HB); line(H); gap(VG - 1); line(H); gap(VG);
        frame(V, H, -1);
        chk("locked_final", locked, 1'b1);

        repeat (5) @(posedge lcd_clk);
        @(negedge lcd_clk);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("line_q_drained", 32'(line_q.size()), 32'd0);
        chk("frame_q_drained", 32'(frame_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_de_receiver.md
# lcd_de_receiver

Receive-side counterpart to the panel RGB driver: accepts a DE-mode RGB565 video stream (HS/VS held high, timing carried only by DE) and recovers frame/line structure. Emits per-pixel coordinates with valid strobes, frame and line markers, and measured active width/height. Flags geometry errors against the expected resolution. Sits at the capture end of a display loopback or at a DE-mode video input, feeding a frame-buffer writer.

## Interface
- H_DISP, 11'd800, expected active pixels per line
- V_DISP, 11'd480, expected active lines per frame
- VGAP_MIN, 12'd1024, DE-low run length (cycles) that marks vertical blanking; must exceed max horizontal blank and be below min vertical blank

- lcd_clk  in  1  pixel clock; all logic on rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- de_in  in  1  data enable from source
- rgb_in  in  16  RGB565 pixel data, valid when de_in=1
- pix_valid  out  1  pixel output strobe
- pix_data  out  16  captured pixel
- pix_x  out  11  column of pix_data, 0-based
- pix_y  out  11  row of pix_data, 0-based
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- line_end  out  1  one-cycle pulse, cycle after a line's last pixel
- frame_done  out  1  one-cycle pulse when vertical blank is detected after a frame
- meas_width  out  11  active length of most recent line
- meas_height  out  11  line count of most recent frame
- err_width  out  1  one-cycle pulse with line_end when line length != H_DISP
- err_height  out  1  one-cycle pulse with frame_done when line count != V_DISP
- locked  out  1  last complete frame matched H_DISP x V_DISP with no errors

## Operation
- All outputs reset to 0; state HUNT; counters 0; de_d (registered de_in) 0.
- HUNT: gap counter increments while de_in=0, clears when de_in=1; no pixel output. gap >= VGAP_MIN-1 -> VBLANK. Stream joined mid-frame is discarded until a vertical gap.
- VBLANK: wait de_in=1 -> LINE with y=0, x=0; frame_start, pix_valid asserted for that pixel; frame error flag cleared.
- LINE: each de_in=1 cycle outputs pixel, x increments. de_in=0 -> HBLANK; line_end pulses; meas_width <= x count; err_width if count != H_DISP; gap counter cleared.
- HBLANK: gap counts de_in=0 cycles. de_in=1 before reaching VGAP_MIN -> LINE, y+1, x=0. gap reaches VGAP_MIN-1 -> VBLANK; frame_done pulses; meas_height <= y+1; err_height if != V_DISP.
- locked: set at frame_done if no err_width/err_height occurred in that frame; cleared on the same edge as any err_width or err_height pulse; cleared by reset.
- Width rules: x and line-length counters saturate at 2047 (line longer is err_width); y saturates at 2047; gap counter 12-bit, saturates at 4095.
- Single-cycle DE pulse is a valid 1-pixel line (meas_width=1, err_width).
- Reset asserted mid-line: immediate return to HUNT, all outputs 0; next frame requires a full vertical gap.

## Timing
- Latency 1 cycle: de_in/rgb_in sampled at edge n appear on pix_valid/pix_data/pix_x/pix_y after edge n (registered).
- line_end registered on the edge sampling the first de_in=0 after a line, i.e. same cycle pix_valid falls.
- frame_done fires VGAP_MIN cycles after the last line's falling DE (counting the line_end cycle as gap 1).
- frame_start coincides exactly with pix_valid for (0,0); never asserted in HUNT.
- No backpressure: consumer must accept one pixel per cycle.

## Test plan
- Reset then 800x480 DE stream (H_TOTAL 1056, V_TOTAL 525, vertical blank 45 lines) -> first partial frame ignored; next frame: frame_start at (0,0), pix_x 0..799, pix_y 0..479, frame_done, meas_width=800, meas_height=480, locked=1 after frame_done.
- Ramp data rgb_in=x+y -> pix_data equals pix_x+pix_y every valid cycle, 1-cycle latency.
- One line of 799 pixels in frame -> err_width pulse at that line_end, meas_width=799, locked drops immediately, returns to 1 after next clean frame.
- Frame of 479 lines -> err_height with frame_done, meas_height=479, locked=0.
- Horizontal gap of VGAP_MIN-2 cycles -> no frame_done; gap of VGAP_MIN -> frame_done, next DE gives frame_start with y=0.
- sys_rst_n pulsed low mid-line -> all outputs 0 next cycle; no pix_valid until a VGAP_MIN gap then DE rise.
